// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, sequencer states
// and the default register-address width.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mc_seq.sv
// Multi-cycle execute sequencer: keeps a multi-cycle op in E for MC_LAT cycles.
// freeze_i holds state and count (data-memory wait has priority).
module mc_seq
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic mc_start_i,
    input  logic freeze_i,
    output logic mcstall_o,
    output logic mc_busy_o
);

    localparam int unsigned CntW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;
    localparam bit          MultiCycle = (MC_LAT > 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcstall_o = 1'b0;
        mc_busy_o = (state_q == MC_BUSY);
        unique case (state_q)
            RUN: begin
                // The start cycle itself is the first stall cycle.
                if (mc_start_i && MultiCycle) begin
                    mcstall_o = 1'b1;
                    state_d   = MC_BUSY;
                    cnt_d     = CntW'(MC_LAT - 2);
                end
            end
            MC_BUSY: begin
                if (cnt_q != '0) begin
                    mcstall_o = 1'b1;
                    cnt_d     = cnt_q - CntW'(1);
                end else begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        if (freeze_i) begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32 pipeline.
// Optional HAZARD_STATS_EN adds saturating stall/flush event counters.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MC_LAT = 4,
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              load_e,
    input  logic              regwr_m,
    input  logic              regwr_w,
    input  logic              pc_src_e,
    input  logic              mc_start_e,
    input  logic              dmem_req_m,
    input  logic              dmem_ready,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              stall_m,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              flush_w,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
`ifdef HAZARD_STATS_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              mc_busy
);

    logic memwait, lduse, mcstall, seq_busy;

    assign memwait = dmem_req_m & ~dmem_ready;
    assign lduse   = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    mc_seq #(
        .MC_LAT(MC_LAT)
    ) u_mc_seq (
        .clk_i     (clk),
        .rst_ni    (rst),
        .mc_start_i(mc_start_e),
        .freeze_i  (memwait),
        .mcstall_o (mcstall),
        .mc_busy_o (seq_busy)
    );

    function automatic fwd_sel_t fwd_sel(input logic [REG_AW-1:0] rs);
        if (regwr_m && (rd_m != '0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (regwr_w && (rd_w != '0) && (rd_w == rs)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    // Outputs are forced low while reset is asserted, even with live inputs.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        flush_w = 1'b0;
        fwd_a_e = FWD_RF;
        fwd_b_e = FWD_RF;
        mc_busy = 1'b0;
        if (rst) begin
            fwd_a_e = fwd_sel(rs1_e);
            fwd_b_e = fwd_sel(rs2_e);
            mc_busy = seq_busy;
            if (memwait) begin
                {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                flush_w = 1'b1;
            end else if (mcstall) begin
                {stall_f, stall_d, stall_e} = 3'b111;
                flush_m = 1'b1;
            end else if (pc_src_e) begin
                // Wrong-path D instruction: branch wins over load-use.
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lduse) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (flush_e && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// checked against a cycle-level model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MC_LAT = 4;
    localparam int unsigned AW     = 5;

    typedef struct packed {
        logic          rst;
        logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic          load_e, regwr_m, regwr_w, pc_src_e, mc_start_e, dmem_req_m, dmem_ready;
    } stim_t;

    typedef struct packed {
        logic [3:0]  stall;  // {f,d,e,m}
        logic [3:0]  flush;  // {d,e,m,w}
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        busy;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          load_e, regwr_m, regwr_w, pc_src_e, mc_start_e, dmem_req_m, dmem_ready;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_m, flush_w;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic          mc_busy;
    logic [31:0]   stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MC_LAT(MC_LAT),
        .REG_AW(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs1_d     (rs1_d),
        .rs2_d     (rs2_d),
        .rs1_e     (rs1_e),
        .rs2_e     (rs2_e),
        .rd_e      (rd_e),
        .rd_m      (rd_m),
        .rd_w      (rd_w),
        .load_e    (load_e),
        .regwr_m   (regwr_m),
        .regwr_w   (regwr_w),
        .pc_src_e  (pc_src_e),
        .mc_start_e(mc_start_e),
        .dmem_req_m(dmem_req_m),
        .dmem_ready(dmem_ready),
        .stall_f   (stall_f),
        .stall_d   (stall_d),
        .stall_e   (stall_e),
        .stall_m   (stall_m),
        .flush_d   (flush_d),
        .flush_e   (flush_e),
        .flush_m   (flush_m),
        .flush_w   (flush_w),
        .fwd_a_e   (fwd_a_e),
        .fwd_b_e   (fwd_b_e),
`ifdef HAZARD_STATS_EN
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt),
`endif
        .mc_busy   (mc_busy)
    );

`ifndef HAZARD_STATS_EN
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    // Reference model: occ = E-stage cycles already spent by the current multi-cycle op.
    int          occ = 0;
    logic [31:0] m_sc = '0, m_fc = '0;
    exp_t        sb_q[$];
    int          n_cmp = 0, n_bad = 0;

    function automatic logic [1:0] ref_fwd(stim_t s, logic [AW-1:0] rs);
        if (s.regwr_m && s.rd_m != 0 && s.rd_m == rs) return 2'b10;
        if (s.regwr_w && s.rd_w != 0 && s.rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t ref_out(stim_t s);
        exp_t e;
        bit   memwait, lduse, mcst;
        e = '0;
        if (!s.rst) return e;
        memwait = s.dmem_req_m && !s.dmem_ready;
        lduse   = s.load_e && s.rd_e != 0 && (s.rd_e == s.rs1_d || s.rd_e == s.rs2_d);
        mcst    = (occ == 0) ? (s.mc_start_e && MC_LAT > 1) : (occ < int'(MC_LAT) - 1);
        if (memwait) begin
            e.stall = 4'b1111; e.flush = 4'b0001;
        end else if (mcst) begin
            e.stall = 4'b1110; e.flush = 4'b0010;
        end else if (s.pc_src_e) begin
            e.flush = 4'b1100;
        end else if (lduse) begin
            e.stall = 4'b1100; e.flush = 4'b0100;
        end
        e.fa   = ref_fwd(s, s.rs1_e);
        e.fb   = ref_fwd(s, s.rs2_e);
        e.busy = (occ != 0);
`ifdef HAZARD_STATS_EN
        e.sc = m_sc;
        e.fc = m_fc;
`endif
        return e;
    endfunction

    task automatic drive(stim_t s);
        exp_t e;
        @(negedge clk);
        {rst, rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, load_e, regwr_m, regwr_w,
         pc_src_e, mc_start_e, dmem_req_m, dmem_ready} = s;
        e = ref_out(s);
        sb_q.push_back(e);
        if (!s.rst) begin
            occ  = 0;
            m_sc = '0;
            m_fc = '0;
        end else begin
            if (e.stall[3] && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (e.flush[2] && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
            if (!(s.dmem_req_m && !s.dmem_ready)) begin
                if (occ == 0) occ = (s.mc_start_e && MC_LAT > 1) ? 1 : 0;
                else if (occ < int'(MC_LAT) - 1) occ = occ + 1;
                else occ = 0;
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; sample mid-low-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("stall_fdem", 32'({stall_f, stall_d, stall_e, stall_m}), 32'(e.stall));
                chk("flush_demw", 32'({flush_d, flush_e, flush_m, flush_w}), 32'(e.flush));
                chk("fwd_a_e", 32'(fwd_a_e), 32'(e.fa));
                chk("fwd_b_e", 32'(fwd_b_e), 32'(e.fb));
                chk("mc_busy", 32'(mc_busy), 32'(e.busy));
`ifdef HAZARD_STATS_EN
                chk("stall_cnt", stall_cnt, e.sc);
                chk("flush_cnt", flush_cnt, e.fc);
`endif
            end
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        s.dmem_ready = 1'b1;
        return s;
    endfunction

    initial begin
        stim_t s;
        {rst, rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, load_e, regwr_m, regwr_w,
         pc_src_e, mc_start_e, dmem_req_m, dmem_ready} = '0;

        // Reset with live hazard inputs: everything must read 0.
        s = idle(); s.rst = 0; s.mc_start_e = 1; s.regwr_m = 1; s.rd_m = 5; s.rs1_e = 5;
        s.dmem_req_m = 1; s.dmem_ready = 0;
        drive(s); drive(s);

        // Forwarding priority M > W > regfile.
        s = idle(); s.rd_m = 5; s.regwr_m = 1; s.rd_w = 5; s.regwr_w = 1; s.rs1_e = 5; s.rs2_e = 5;
        drive(s);
        s.regwr_m = 0; drive(s);
        s.rd_m = 0; s.rd_w = 0; s.regwr_m = 1; drive(s);

        // Load-use then bubble; then rd_e == x0.
        s = idle(); s.load_e = 1; s.rd_e = 3; s.rs2_d = 3; drive(s);
        drive(idle());
        s = idle(); s.load_e = 1; s.rd_e = 0; drive(s);

        // Branch overriding load-use.
        s = idle(); s.load_e = 1; s.rd_e = 3; s.rs1_d = 3; s.pc_src_e = 1; drive(s);

        // Multi-cycle op held in E until released.
        s = idle(); s.mc_start_e = 1;
        repeat (MC_LAT) drive(s);
        drive(idle()); drive(idle());

        // Memory wait while cnt == 1.
        s = idle(); s.mc_start_e = 1;
        drive(s); drive(s);
        s.dmem_req_m = 1; s.dmem_ready = 0; drive(s); drive(s);
        s.dmem_ready = 1; drive(s);
        s.dmem_req_m = 0; drive(s);
        drive(idle()); drive(idle());

        // Asynchronous reset mid-op.
        s = idle(); s.mc_start_e = 1; s.load_e = 1; s.rd_e = 2; s.rs1_d = 2;
        drive(s); drive(s);
        s.rst = 0; drive(s);
        drive(idle()); drive(idle());

        // Random traffic over a small register set to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst        = ($urandom_range(0, 199) != 0);
            s.rs1_d      = AW'($urandom_range(0, 3));
            s.rs2_d      = AW'($urandom_range(0, 3));
            s.rs1_e      = AW'($urandom_range(0, 3));
            s.rs2_e      = AW'($urandom_range(0, 3));
            s.rd_e       = AW'($urandom_range(0, 3));
            s.rd_m       = AW'($urandom_range(0, 3));
            s.rd_w       = AW'($urandom_range(0, 3));
            s.load_e     = 1'($urandom_range(0, 1));
            s.regwr_m    = 1'($urandom_range(0, 1));
            s.regwr_w    = 1'($urandom_range(0, 1));
            s.pc_src_e   = ($urandom_range(0, 3) == 0);
            s.mc_start_e = ($urandom_range(0, 5) == 0);
            s.dmem_req_m = 1'($urandom_range(0, 1));
            s.dmem_ready = ($urandom_range(0, 2) != 0);
            drive(s);
        end

        drive(idle()); drive(idle());
        @(negedge clk); #4;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
